pipeline_stall_ctrl: RTL

//  Parametrised pipeline hazard controller: STAGES-wide stall requests, registered exception flush, stall telemetry.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 26 ++
 rtl/pipeline_stall_ctrl_prefix_enc.sv | 27 ++
 rtl/pipeline_stall_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: reset/stall levels,
// stage indices (bit position of each stage in the stall vector) and the
// flush sequencer state encoding.
package pipeline_stall_ctrl_pkg;

  // Reset and stall-request polarities
  localparam logic RST_ENABLE = 1'b1;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;

  // Stage indices into stallreq/stall
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;
  localparam int STG_NUM = STG_WB + 1;

  // Flush sequencer states
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_prefix_enc.sv
// Purpose : turns per-stage stall requests into a thermometer hold mask
//           (highest requesting stage and every younger stage hold).
// Latency : combinational, 0 cycles. Backpressure: none, pure function.
// Ports   : i_stallreq [STAGES] request bits in; o_mask [STAGES] hold mask out.
module stall_prefix_enc
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int STAGES = STG_NUM
) (
  input  logic [STAGES-1:0] i_stallreq,
  output logic [STAGES-1:0] o_mask
);

  logic w_acc;

  // Walk from the oldest stage downwards; once any request is seen every
  // lower-index bit holds too, which yields bits [k:0] set.
  always_comb begin
    w_acc  = NO_STOP;
    o_mask = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_acc     = w_acc | (i_stallreq[i] == STOP);
      o_mask[i] = w_acc;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Purpose : pipeline hazard controller - stall mask, one-cycle exception flush
//           with PC redirect, saturating stall-cycle counter, stall watchdog.
// Latency : stall is combinational; flush/new_pc appear 1 cycle after excp_req.
// Backpressure: none; excp_req arriving during the flush cycle is dropped.
// Ports   : clk, resetn (sync, active-high); stallreq/excp_req/excp_vector in;
//           stall, flush, new_pc, stall_cnt, watchdog_err out.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int STAGES    = STG_NUM,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [STAGES-1:0] stallreq,
  input  logic              excp_req,
  input  logic [ADDR_W-1:0] excp_vector,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              watchdog_err
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_latch;
  logic [STAGES-1:0]  w_mask;
  logic               w_stalled;
  logic [ADDR_W-1:0]  r_new_pc;
  logic [CNT_W-1:0]   r_stall_cnt;

  stall_prefix_enc #(
    .STAGES (STAGES)
  ) u_enc (
    .i_stallreq (stallreq),
    .o_mask     (w_mask)
  );

  // The flush cycle clears every pipeline register, so holding any of them
  // at the same time would be meaningless; reset also masks the stall.
  always_comb begin
    stall = w_mask;
    if (resetn == RST_ENABLE || r_state == ST_FLUSH) begin
      stall = '0;
    end
  end

  assign w_stalled = |stall;

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (excp_req) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn == RST_ENABLE) begin
      r_state     <= ST_RUN;
      r_new_pc    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_new_pc <= excp_vector;
      end
      if (w_stalled && r_stall_cnt != {CNT_W{1'b1}}) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign flush     = (r_state == ST_FLUSH);
  assign new_pc    = r_new_pc;
  assign stall_cnt = r_stall_cnt;

  generate
    if (MAX_STALL > 0) begin : g_wdog
      localparam int RUN_W = $clog2(MAX_STALL + 1);
      logic [RUN_W-1:0] r_run;
      logic             r_wd_err;

      always_ff @(posedge clk) begin
        if (resetn == RST_ENABLE) begin
          r_run    <= '0;
          r_wd_err <= 1'b0;
        end else if (w_stalled) begin
          if (r_run != RUN_W'(MAX_STALL)) begin
            r_run <= r_run + 1'b1;
          end
          // This stalled cycle brings the run length to MAX_STALL.
          if (r_run >= RUN_W'(MAX_STALL - 1)) begin
            r_wd_err <= 1'b1;
          end
        end else begin
          r_run <= '0;
        end
      end

      assign watchdog_err = r_wd_err;
    end else begin : g_no_wdog
      assign watchdog_err = 1'b0;
    end
  endgenerate

endmodule
